// File: rtl/nes_pkg.sv
// Shared constants and FSM state type for the multi-pad NES controller reader.
package nes_pkg;
  localparam int NES_BTN_W = 8;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    CLK_LO,
    CLK_HI,
    DONE
  } nes_state_e;
endpackage

// File: rtl/nes_pad_shift.sv
// Per-pad datapath: input synchroniser, serial capture, optional debounce and press detect.
// Debounce history exists only when NES_DEBOUNCE_EN is defined.
module nes_pad_shift
  import nes_pkg::*;
(
  input  logic                 clk,
  input  logic                 srst,
  input  logic                 data_n_i,
  input  logic                 sample_i,
  input  logic                 publish_i,
  output logic [NES_BTN_W-1:0] buttons_o,
  output logic [NES_BTN_W-1:0] pressed_o
);
  logic                 sync1_q, sync2_q;
  logic [NES_BTN_W-1:0] sr_q, btn_q, evt_q, btn_d;

`ifdef NES_DEBOUNCE_EN
  logic [NES_BTN_W-1:0] hist_q, stable;

  // A bit only moves when two consecutive raw frames agree on it.
  assign stable = ~(sr_q ^ hist_q);
  assign btn_d  = (stable & sr_q) | (~stable & btn_q);

  always_ff @(posedge clk) begin
    if (srst) begin
      hist_q <= '0;
    end else if (publish_i) begin
      hist_q <= sr_q;
    end
  end
`else
  assign btn_d = sr_q;
`endif

  always_ff @(posedge clk) begin
    if (srst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sr_q    <= '0;
      btn_q   <= '0;
      evt_q   <= '0;
    end else begin
      sync1_q <= data_n_i;
      sync2_q <= sync1_q;
      // Button A arrives first, so after eight shifts it sits in bit 0.
      if (sample_i) begin
        sr_q <= {~sync2_q, sr_q[BTN_RIGHT:BTN_A+1]};
      end
      if (publish_i) begin
        btn_q <= btn_d;
      end
      evt_q <= publish_i ? (btn_d & ~btn_q) : '0;
    end
  end

  assign buttons_o = btn_q;
  assign pressed_o = evt_q;
endmodule

// File: rtl/nes_multi_reader.sv
// Polls NUM_PADS NES controllers over a shared latch/clock and publishes one frame per poll.
// Optional NES_DEBOUNCE_EN requires a button value to persist for two polls.
module nes_multi_reader
  import nes_pkg::*;
#(
  parameter int NUM_PADS = 2,
  parameter int HALF_DIV = 300,
  parameter int POLL_DIV = 833333
) (
  input  logic                          clock_50mhz,
  input  logic                          reset,
  input  logic [NUM_PADS-1:0]           nes_data,
  input  logic                          poll_req,
  output logic                          clklatch,
  output logic                          clkout,
  output logic [NES_BTN_W*NUM_PADS-1:0] buttons,
  output logic [NES_BTN_W*NUM_PADS-1:0] pressed_evt,
  output logic                          frame_valid,
  output logic                          busy
);
  localparam int POLL_W = $clog2(POLL_DIV);
  localparam int HC_W   = $clog2(2 * HALF_DIV);

  nes_state_e        state_q, state_d;
  logic [POLL_W-1:0] poll_q, poll_d;
  logic [HC_W-1:0]   hcnt_q, hcnt_d;
  logic [2:0]        bit_q, bit_d;
  logic              poll_tick, half_last, sample, publish;

  assign poll_tick = (poll_q == POLL_W'(POLL_DIV - 1));
  assign poll_d    = poll_tick ? '0 : poll_q + 1'b1;
  assign half_last = (hcnt_q == HC_W'(HALF_DIV - 1));

  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    bit_d   = bit_q;
    sample  = 1'b0;
    publish = 1'b0;
    case (state_q)
      IDLE: begin
        // Requests arriving while busy are dropped, not queued.
        if (poll_tick || poll_req) begin
          state_d = LATCH;
          hcnt_d  = '0;
        end
      end
      LATCH: begin
        if (hcnt_q == HC_W'(2 * HALF_DIV - 1)) begin
          state_d = CLK_LO;
          hcnt_d  = '0;
          bit_d   = '0;
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end
      CLK_LO: begin
        if (half_last) begin
          sample  = 1'b1;
          state_d = CLK_HI;
          hcnt_d  = '0;
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end
      CLK_HI: begin
        if (half_last) begin
          hcnt_d = '0;
          bit_d  = bit_q + 1'b1;
          if (bit_q == 3'd7) begin
            // Registers load on this edge so the new frame is visible during DONE.
            state_d = DONE;
            publish = 1'b1;
          end else begin
            state_d = CLK_LO;
          end
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_50mhz) begin
    if (reset) begin
      state_q <= IDLE;
      poll_q  <= '0;
      hcnt_q  <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      poll_q  <= poll_d;
      hcnt_q  <= hcnt_d;
      bit_q   <= bit_d;
    end
  end

  assign clklatch    = (state_q == LATCH);
  assign clkout      = (state_q == CLK_HI);
  assign frame_valid = (state_q == DONE);
  assign busy        = (state_q != IDLE);

  for (genvar gi = 0; gi < NUM_PADS; gi++) begin : g_pad
    nes_pad_shift u_pad (
      .clk       (clock_50mhz),
      .srst      (reset),
      .data_n_i  (nes_data[gi]),
      .sample_i  (sample),
      .publish_i (publish),
      .buttons_o (buttons[NES_BTN_W*gi +: NES_BTN_W]),
      .pressed_o (pressed_evt[NES_BTN_W*gi +: NES_BTN_W])
    );
  end
endmodule

// File: tb/tb_nes_multi_reader.sv
// Self-checking bench for nes_multi_reader with behavioural NES pads and a frame-level model.
module tb_nes_multi_reader;
  localparam int NP = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [NP-1:0]   nes_data;
  logic            poll_req = 1'b0;
  logic            clklatch, clkout, frame_valid, busy;
  logic [8*NP-1:0] buttons, pressed_evt;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [7:0] pad_btn [NP];
  logic [7:0] m_btn   [NP];
  logic [7:0] m_prev  [NP];
  int         pad_idx = 8;
  logic       ck_prev = 1'b0;
  int         lat_cnt = 0, ck_hi = 0, ck_rise = 0;
  logic       ck_prev_n = 1'b0;

  nes_multi_reader #(.NUM_PADS(NP), .HALF_DIV(4), .POLL_DIV(200)) dut (
    .clock_50mhz (clk),
    .reset       (reset),
    .nes_data    (nes_data),
    .poll_req    (poll_req),
    .clklatch    (clklatch),
    .clkout      (clkout),
    .buttons     (buttons),
    .pressed_evt (pressed_evt),
    .frame_valid (frame_valid),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // A 4021-style pad: latch presents A, each clock rising edge advances one button.
  always @(posedge clk) begin
    ck_prev <= clkout;
    if (clklatch) pad_idx <= 0;
    else if (clkout && !ck_prev && pad_idx < 8) pad_idx <= pad_idx + 1;
  end

  always_comb begin
    nes_data = '0;
    for (int p = 0; p < NP; p++)
      nes_data[p] = (pad_idx < 8) ? ~pad_btn[p][pad_idx] : 1'b0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (clklatch === 1'b1) lat_cnt++;
    if (clkout === 1'b1) ck_hi++;
    if (clkout === 1'b1 && !ck_prev_n) ck_rise++;
    ck_prev_n = clkout;
    if (!reset && frame_valid !== 1'b1) chk("evt_outside_done", pressed_evt, 0);
  end

  // Frame-level model: raw frame = pad buttons; debounce keeps a bit unless two raw frames agree.
  task automatic model_frame(output logic [15:0] eb, output logic [15:0] ee);
    logic [7:0] raw, nb;
    eb = '0;
    ee = '0;
    for (int p = 0; p < NP; p++) begin
      raw = pad_btn[p];
      for (int b = 0; b < 8; b++) begin
`ifdef NES_DEBOUNCE_EN
        nb[b] = (raw[b] == m_prev[p][b]) ? raw[b] : m_btn[p][b];
`else
        nb[b] = raw[b];
`endif
        ee[8*p+b] = nb[b] && !m_btn[p][b];
      end
      eb[8*p +: 8] = nb;
      m_prev[p] = raw;
      m_btn[p]  = nb;
    end
  endtask

  task automatic clear_mon();
    lat_cnt = 0;
    ck_hi   = 0;
    ck_rise = 0;
  endtask

  task automatic model_reset();
    for (int p = 0; p < NP; p++) begin
      m_btn[p]  = '0;
      m_prev[p] = '0;
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_latch"}, clklatch, 0);
    chk({tag, "_clkout"}, clkout, 0);
    chk({tag, "_buttons"}, buttons, 0);
    chk({tag, "_evt"}, pressed_evt, 0);
    chk({tag, "_fv"}, frame_valid, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk_zero("in_reset");
    reset = 1'b0;
    model_reset();
    clear_mon();
  endtask

  task automatic step_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wait_frame(input string tag, input int exp_cyc);
    logic [15:0] eb, ee;
    int n;
    n = 0;
    while (frame_valid !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_seen"}, frame_valid, 1);
    if (frame_valid === 1'b1) begin
      model_frame(eb, ee);
      $display("frame %s cyc=%0d buttons=%h evt=%h exp=%h/%h", tag, cyc, buttons, pressed_evt, eb, ee);
      chk({tag, "_cycle"}, cyc, exp_cyc);
      chk({tag, "_buttons"}, buttons, eb);
      chk({tag, "_evt"}, pressed_evt, ee);
      chk({tag, "_busy"}, busy, 1);
      chk({tag, "_latch_cycles"}, lat_cnt, 8);
      chk({tag, "_clk_pulses"}, ck_rise, 8);
      chk({tag, "_clk_hi_cycles"}, ck_hi, 32);
    end
    clear_mon();
    @(negedge clk);
    chk({tag, "_fv_drop"}, frame_valid, 0);
    chk({tag, "_busy_drop"}, busy, 0);
  endtask

  task automatic wait_no_frame(input string tag, input int n);
    int seen;
    seen = 0;
    repeat (n) begin
      if (frame_valid === 1'b1) seen++;
      @(negedge clk);
    end
    $display("quiet %s cyc=%0d frames=%0d", tag, cyc, seen);
    chk(tag, seen, 0);
  endtask

  task automatic pulse_req();
    poll_req = 1'b1;
    @(negedge clk);
    poll_req = 1'b0;
  endtask

  initial begin
    int t;
    pad_btn[0] = 8'h01;
    pad_btn[1] = 8'h00;
    model_reset();

    // Automatic polls: A pressed, then held, then Right on pad 1.
    do_reset();
    wait_frame("first", 272);
    wait_frame("held", 472);
    pad_btn[1] = 8'h80;
    wait_frame("right", 672);
    wait_frame("right_held", 872);

    // Immediate poll request, plus a request while busy that must be dropped.
    do_reset();
    step_to(50);
    chk("req_latch_before", clklatch, 0);
    pulse_req();
    chk("req_latch_rise", clklatch, 1);
    step_to(60);
    pulse_req();
    wait_frame("req", 123);
    wait_no_frame("busy_req_dropped", 73);
    wait_frame("tick_after_req", 272);

    // Tick and request in the same cycle yield one frame.
    step_to(399);
    pulse_req();
    wait_frame("coincident", 472);
    wait_no_frame("coincident_single", 73);
    wait_frame("coincident_next", 672);

    // Random button patterns on successive polls.
    t = 672;
    for (int i = 0; i < 6; i++) begin
      pad_btn[0] = 8'($urandom);
      pad_btn[1] = 8'($urandom);
      t += 200;
      wait_frame("random", t);
    end

    // Start glitch for one poll, then held for two.
    pad_btn[0] = 8'h00;
    pad_btn[1] = 8'h00;
    t += 200; wait_frame("clear_a", t);
    t += 200; wait_frame("clear_b", t);
    pad_btn[0] = 8'h08;
    t += 200; wait_frame("start_glitch", t);
`ifdef NES_DEBOUNCE_EN
    chk("glitch_start_bit", buttons[3], 0);
`endif
    pad_btn[0] = 8'h00;
    t += 200; wait_frame("start_gone", t);
    pad_btn[0] = 8'h08;
    t += 200; wait_frame("start_1", t);
    t += 200; wait_frame("start_2", t);
    chk("start_set_after_two", buttons[3], 1);

    // Reset during the high phase of bit 4 aborts the frame.
    do_reset();
    step_to(245);
    chk("mid_clkout_hi", clkout, 1);
    chk("mid_busy", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    chk_zero("mid_reset");
    reset = 1'b0;
    model_reset();
    clear_mon();
    wait_no_frame("aborted_no_frame", 73);
    wait_frame("after_abort", 272);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
